// File: rtl/input_pkg.sv
// Shared types and sizing helpers for the button event path.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } btn_state_t;

    // Tick counter must hold the larger of the two reload values.
    function automatic int cnt_width(input int hold_delay, input int repeat_period);
        int max_load;
        max_load = (hold_delay > repeat_period) ? hold_delay : repeat_period;
        return $clog2(max_load + 1);
    endfunction

    // A divide-by-one prescaler still needs a one-bit register.
    function automatic int div_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, press/hold/repeat FSM and its tick counter.
//   state   | meaning
//   IDLE    | button released, no events pending
//   PRESSED | held, counting ticks towards the first repeat
//   REPEAT  | held, emitting a repeat every RepeatPeriod ticks
module button_channel
    import input_pkg::*;
#(
    parameter int HoldDelay    = 500,
    parameter int RepeatPeriod = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic tick,
    output logic held,
    output logic pressed,
    output logic released,
    output logic repeated
);

    localparam int CntW = cnt_width(HoldDelay, RepeatPeriod);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HoldDelay);
    localparam logic [CntW-1:0] RepLoad  = CntW'(RepeatPeriod);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    logic            s1_q, s2_q;
    btn_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            held_q, held_d;
    logic            pressed_q, pressed_d;
    logic            released_q, released_d;
    logic            repeated_q, repeated_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            repeated_q <= 1'b0;
        end else begin
            s1_q       <= btn_in;
            s2_q       <= s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            repeated_q <= repeated_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        repeated_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d   = PRESSED;
                    cnt_d     = HoldLoad;
                    pressed_d = 1'b1;
                end
            end
            PRESSED, REPEAT: begin
                // Release wins over a coincident tick, so no repeat in that cycle.
                if (!s2_q) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                end else if (tick) begin
                    if (cnt_q == CntOne) begin
                        state_d    = REPEAT;
                        cnt_d      = RepLoad;
                        repeated_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d != IDLE);
    end

    assign held     = held_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign repeated = repeated_q;

endmodule

// File: rtl/button_events.sv
// Per-button press/release/repeat event generator with a shared free-running tick prescaler.
module button_events
    import input_pkg::*;
#(
    parameter int Width        = 8,
    parameter int TickDiv      = 1000,
    parameter int HoldDelay    = 500,
    parameter int RepeatPeriod = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] btn_in,
    output logic [Width-1:0] held,
    output logic [Width-1:0] pressed,
    output logic [Width-1:0] released,
    output logic [Width-1:0] repeated
);

    localparam int DivW = div_width(TickDiv);
    localparam logic [DivW-1:0] DivLoad = DivW'(TickDiv - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    assign tick  = (div_q == '0);
    assign div_d = tick ? DivLoad : div_q - DivW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= DivLoad;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < Width; g++) begin : g_chan
        button_channel #(
            .HoldDelay   (HoldDelay),
            .RepeatPeriod(RepeatPeriod)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .btn_in  (btn_in[g]),
            .tick    (tick),
            .held    (held[g]),
            .pressed (pressed[g]),
            .released(released[g]),
            .repeated(repeated[g])
        );
    end

endmodule
